// File: rtl/pwm_pkg.sv
// Shared defaults, FSM state encodings and helpers for the PWM duty-cycle controller.
package pwm_pkg;

  localparam int DUTY_W       = 4;
  localparam int DUTY_MAX     = 10;
  localparam int DUTY_RST     = 5;
  localparam int DEB_CYCLES   = 8;
  localparam int REPEAT_DELAY = 500;
  localparam int REPEAT_RATE  = 100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_HOLD_INC = 2'd1;
  localparam state_t ST_HOLD_DEC = 2'd2;
  localparam state_t ST_BOTH     = 2'd3;

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Duty configuration bus from the controller to the PWM counter/comparator.
interface pwm_duty_ctrl_if #(parameter int DUTY_W = pwm_pkg::DUTY_W);
  logic [DUTY_W-1:0] duty;
  logic              duty_upd;
  logic              inled;
  logic              deled;
  logic              at_limit;

  modport master (output duty, duty_upd, inled, deled, at_limit);
  modport slave  (input  duty, duty_upd, inled, deled, at_limit);
endinterface

// File: rtl/pwm_duty_ctrl_btn_debounce.sv
// Two-flop synchroniser plus level debouncer for one raw push-button pin.
module btn_debounce
  import pwm_pkg::*;
#(
  parameter int DEB_CYCLES = pwm_pkg::DEB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // any sample agreeing with the accepted level restarts the stability count
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Button-driven saturating duty register with single-step and auto-repeat control.
//   state       | meaning
//   ST_IDLE     | no button held, waiting for a fresh press
//   ST_HOLD_INC | increment held, auto-repeat timer running
//   ST_HOLD_DEC | decrement held, auto-repeat timer running
//   ST_BOTH     | both buttons seen together, steps blocked until both released
module pwm_duty_ctrl
  import pwm_pkg::*;
#(
  parameter int DUTY_W       = pwm_pkg::DUTY_W,
  parameter int DUTY_MAX     = pwm_pkg::DUTY_MAX,
  parameter int DUTY_RST     = pwm_pkg::DUTY_RST,
  parameter int DEB_CYCLES   = pwm_pkg::DEB_CYCLES,
  parameter int REPEAT_DELAY = pwm_pkg::REPEAT_DELAY,
  parameter int REPEAT_RATE  = pwm_pkg::REPEAT_RATE
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_incrPWM,
  input  logic btn_decrPWM,
  pwm_duty_ctrl_if.master bus
);

  localparam int CTR_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CTR_W-1:0]  RPT_DELAY = CTR_W'(REPEAT_DELAY);
  localparam logic [CTR_W-1:0]  RPT_RATE  = CTR_W'(REPEAT_RATE);
  localparam logic [DUTY_W-1:0] D_MAX     = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] D_RST     = DUTY_W'(DUTY_RST);

  logic db_inc;
  logic db_dec;
  logic db_inc_q;
  logic db_dec_q;
  logic rise_inc;
  logic rise_dec;

  state_t            state;
  state_t            state_nxt;
  logic [CTR_W-1:0]  rpt;
  logic [CTR_W-1:0]  rpt_nxt;
  logic              step_inc;
  logic              step_dec;
  logic              inc_ok;
  logic              dec_ok;
  logic [DUTY_W-1:0] duty_r;
  logic              inc_hit;
  logic              dec_hit;
  logic              inled_r;
  logic              deled_r;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_incrPWM),
    .level (db_inc)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_decrPWM),
    .level (db_dec)
  );

  assign rise_inc = db_inc & ~db_inc_q;
  assign rise_dec = db_dec & ~db_dec_q;

  // Terminal count is 1 so repeat steps land exactly DELAY/RATE cycles apart.
  always_comb begin
    state_nxt = state;
    rpt_nxt   = rpt;
    step_inc  = 1'b0;
    step_dec  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (db_inc && db_dec) begin
          state_nxt = ST_BOTH;
        end else if (rise_inc) begin
          step_inc  = 1'b1;
          rpt_nxt   = RPT_DELAY;
          state_nxt = ST_HOLD_INC;
        end else if (rise_dec) begin
          step_dec  = 1'b1;
          rpt_nxt   = RPT_DELAY;
          state_nxt = ST_HOLD_DEC;
        end
      end
      ST_HOLD_INC: begin
        if (!db_inc) begin
          state_nxt = ST_IDLE;
          rpt_nxt   = '0;
        end else if (db_dec) begin
          state_nxt = ST_BOTH;
          rpt_nxt   = '0;
        end else if (rpt <= CTR_W'(1)) begin
          step_inc = 1'b1;
          rpt_nxt  = RPT_RATE;
        end else begin
          rpt_nxt = rpt - 1'b1;
        end
      end
      ST_HOLD_DEC: begin
        if (!db_dec) begin
          state_nxt = ST_IDLE;
          rpt_nxt   = '0;
        end else if (db_inc) begin
          state_nxt = ST_BOTH;
          rpt_nxt   = '0;
        end else if (rpt <= CTR_W'(1)) begin
          step_dec = 1'b1;
          rpt_nxt  = RPT_RATE;
        end else begin
          rpt_nxt = rpt - 1'b1;
        end
      end
      default: begin
        if (!db_inc && !db_dec) begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  // Saturated steps keep FSM timing but leave duty and the pulses untouched.
  assign inc_ok = step_inc && (duty_r != D_MAX);
  assign dec_ok = step_dec && (duty_r != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      db_inc_q <= 1'b0;
      db_dec_q <= 1'b0;
      state    <= ST_IDLE;
      rpt      <= '0;
      duty_r   <= D_RST;
      inc_hit  <= 1'b0;
      dec_hit  <= 1'b0;
      inled_r  <= 1'b0;
      deled_r  <= 1'b0;
    end else begin
      db_inc_q <= db_inc;
      db_dec_q <= db_dec;
      state    <= state_nxt;
      rpt      <= rpt_nxt;
      if (inc_ok) begin
        duty_r <= duty_r + 1'b1;
      end else if (dec_ok) begin
        duty_r <= duty_r - 1'b1;
      end
      inc_hit <= inc_ok;
      dec_hit <= dec_ok;
      inled_r <= inc_hit;
      deled_r <= dec_hit;
    end
  end

  assign bus.duty     = duty_r;
  assign bus.inled    = inled_r;
  assign bus.deled    = deled_r;
  assign bus.duty_upd = inled_r | deled_r;
  assign bus.at_limit = (duty_r == '0) || (duty_r == D_MAX);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Directed bench for pwm_duty_ctrl: latency, debounce, auto-repeat, saturation, BOTH and mid-hold reset.
module tb_pwm_duty_ctrl;

  logic clk;
  logic reset;
  logic btn_incrPWM;
  logic btn_decrPWM;

  int vectors;
  int miscompares;
  int inc_cnt;
  int dec_cnt;
  int snap_inc;
  int snap_dec;

  pwm_duty_ctrl_if bus_i ();

  pwm_duty_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .btn_incrPWM (btn_incrPWM),
    .btn_decrPWM (btn_decrPWM),
    .bus         (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge, tally pulses, check pulse invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_i.inled === 1'b1) inc_cnt++;
    if (bus_i.deled === 1'b1) dec_cnt++;
    chk("pulse_excl", 32'(bus_i.inled & bus_i.deled), 32'd0);
    chk("upd_match", 32'(bus_i.duty_upd), 32'(bus_i.inled | bus_i.deled));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    inc_cnt     = 0;
    dec_cnt     = 0;
    reset       = 1'b0;
    btn_incrPWM = 1'b0;
    btn_decrPWM = 1'b0;
    #1;

    // reset state
    do_reset();
    chk("rst_duty", 32'(bus_i.duty), 32'd5);
    chk("rst_upd", 32'(bus_i.duty_upd), 32'd0);
    chk("rst_inled", 32'(bus_i.inled), 32'd0);
    chk("rst_deled", 32'(bus_i.deled), 32'd0);
    chk("rst_limit", 32'(bus_i.at_limit), 32'd0);

    // single press: duty moves on edge 11, inled on edge 12 only
    snap_inc = inc_cnt;
    btn_incrPWM = 1'b1;
    ticks(10);
    chk("lat_pre", 32'(bus_i.duty), 32'd5);
    tick();
    chk("lat_duty", 32'(bus_i.duty), 32'd6);
    chk("lat_inled_early", 32'(bus_i.inled), 32'd0);
    tick();
    chk("lat_inled", 32'(bus_i.inled), 32'd1);
    chk("lat_upd", 32'(bus_i.duty_upd), 32'd1);
    tick();
    chk("lat_inled_end", 32'(bus_i.inled), 32'd0);
    ticks(7);
    btn_incrPWM = 1'b0;
    ticks(30);
    chk("single_duty", 32'(bus_i.duty), 32'd6);
    chk("single_count", 32'(inc_cnt - snap_inc), 32'd1);

    // bounce: 3-cycle glitches never reach DEB_CYCLES
    do_reset();
    snap_dec = dec_cnt;
    for (int g = 0; g < 6; g++) begin
      btn_decrPWM = 1'b1;
      ticks(3);
      btn_decrPWM = 1'b0;
      ticks(2);
    end
    ticks(20);
    chk("bounce_duty", 32'(bus_i.duty), 32'd5);
    chk("bounce_deled", 32'(dec_cnt - snap_dec), 32'd0);

    // auto-repeat: steps at edges 11, 511, 611, 711
    do_reset();
    snap_inc = inc_cnt;
    btn_incrPWM = 1'b1;
    ticks(510);
    chk("rpt_pre", 32'(bus_i.duty), 32'd6);
    tick();
    chk("rpt_first", 32'(bus_i.duty), 32'd7);
    ticks(289);
    btn_incrPWM = 1'b0;
    ticks(20);
    chk("rpt_duty", 32'(bus_i.duty), 32'd9);
    chk("rpt_count", 32'(inc_cnt - snap_inc), 32'd4);

    // saturation at DUTY_MAX
    snap_inc = inc_cnt;
    btn_incrPWM = 1'b1;
    ticks(1200);
    btn_incrPWM = 1'b0;
    ticks(20);
    chk("sat_hi_duty", 32'(bus_i.duty), 32'd10);
    chk("sat_hi_limit", 32'(bus_i.at_limit), 32'd1);
    chk("sat_hi_count", 32'(inc_cnt - snap_inc), 32'd1);

    // run down to 0: ten steps at edges 11, 511..1311, rest suppressed
    snap_dec = dec_cnt;
    btn_decrPWM = 1'b1;
    ticks(1950);
    btn_decrPWM = 1'b0;
    ticks(20);
    chk("sat_lo_duty", 32'(bus_i.duty), 32'd0);
    chk("sat_lo_limit", 32'(bus_i.at_limit), 32'd1);
    chk("sat_lo_count", 32'(dec_cnt - snap_dec), 32'd10);
    snap_dec = dec_cnt;
    btn_decrPWM = 1'b1;
    ticks(30);
    btn_decrPWM = 1'b0;
    ticks(20);
    chk("sat_lo_press", 32'(dec_cnt - snap_dec), 32'd0);
    chk("sat_lo_hold", 32'(bus_i.duty), 32'd0);

    // both buttons together: no steps until both released
    do_reset();
    snap_inc = inc_cnt;
    snap_dec = dec_cnt;
    btn_incrPWM = 1'b1;
    btn_decrPWM = 1'b1;
    ticks(40);
    chk("both_duty", 32'(bus_i.duty), 32'd5);
    btn_incrPWM = 1'b0;
    ticks(40);
    chk("both_one_left", 32'(bus_i.duty), 32'd5);
    btn_decrPWM = 1'b0;
    ticks(20);
    chk("both_pulses", 32'((inc_cnt - snap_inc) + (dec_cnt - snap_dec)), 32'd0);
    btn_incrPWM = 1'b1;
    ticks(11);
    chk("both_exit_step", 32'(bus_i.duty), 32'd6);
    btn_incrPWM = 1'b0;
    ticks(20);

    // reset during decrement auto-repeat while the button stays held
    do_reset();
    btn_decrPWM = 1'b1;
    ticks(600);
    chk("mid_pre", 32'(bus_i.duty), 32'd3);
    reset = 1'b1;
    tick();
    chk("mid_rst_duty", 32'(bus_i.duty), 32'd5);
    chk("mid_rst_deled", 32'(bus_i.deled), 32'd0);
    reset = 1'b0;
    ticks(10);
    chk("mid_wait", 32'(bus_i.duty), 32'd5);
    tick();
    chk("mid_step", 32'(bus_i.duty), 32'd4);
    btn_decrPWM = 1'b0;
    ticks(20);
    chk("mid_final", 32'(bus_i.duty), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
Duty-cycle controller for the PWM datapath. Synchronises and debounces the increment/decrement push-buttons and applies single steps plus auto-repeat while a button is held. Maintains the saturating duty register that configures the PWM generator, and drives the inled/deled activity pulses. Sits between the chip's io_in button pins and the PWM counter/comparator.

Parameters:
DUTY_W, 4, width of duty register
DUTY_MAX, 10, upper clamp on duty (duty range 0..DUTY_MAX; must satisfy DUTY_MAX < 2**DUTY_W)
DUTY_RST, 5, duty value loaded at reset
DEB_CYCLES, 8, consecutive stable samples required to accept a button level change
REPEAT_DELAY, 500, cycles from first step to first auto-repeat step
REPEAT_RATE, 100, cycles between subsequent auto-repeat steps

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_incrPWM  input  1  raw increment button, asynchronous, active-high
btn_decrPWM  input  1  raw decrement button, asynchronous, active-high
duty  output  DUTY_W  current duty setting to PWM comparator
duty_upd  output  1  one-cycle pulse in the cycle after duty changes
inled  output  1  one-cycle pulse per applied increment step
deled  output  1  one-cycle pulse per applied decrement step
at_limit  output  1  high while duty == 0 or duty == DUTY_MAX

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high, sampled on rising clk edge only.
- Reset values: duty=DUTY_RST, duty_upd=0, inled=0, deled=0, at_limit=(DUTY_RST==0 or DUTY_RST==DUTY_MAX), FSM=IDLE, synchronisers/debouncers cleared to 0, repeat counter 0.
- Input path per button: 2-flop synchroniser, then debouncer: counter resets whenever sync level == accepted level; when it differs for DEB_CYCLES consecutive cycles, accepted level (db_*) flips and counter clears. Glitch shorter than DEB_CYCLES cycles: no effect.
- Latency: raw edge held stable -> db_* changes after 2+DEB_CYCLES edges; duty register updates on the next edge (total DEB_CYCLES+3); inled/deled and duty_upd assert the edge after duty changes.
- FSM states IDLE, HOLD_INC, HOLD_DEC, BOTH:
  IDLE: db_inc rise and db_dec low -> step +1, load rpt=REPEAT_DELAY, go HOLD_INC. db_dec rise and db_inc low -> step -1, load rpt, go HOLD_DEC. Both high same cycle -> BOTH, no step.
  HOLD_INC/HOLD_DEC: own button released -> IDLE. Other button asserted -> BOTH, no step. rpt reaches 0 -> step, reload REPEAT_RATE; else rpt decrements.
  BOTH: no steps; both db_* low -> IDLE.
- Arithmetic: step +1 at duty==DUTY_MAX and step -1 at duty==0 are suppressed: duty unchanged, no inled/deled, no duty_upd; FSM and repeat timing proceed normally.
- inled/deled never both high; duty_upd high exactly when inled or deled high.
- Reset mid-hold: all state returns to reset values; a button still held after reset release must first be seen as a new rise (db starts 0, so a held button produces one step after DEB_CYCLES+3).

Decomposition:
- Package pwm_pkg: DUTY_W, DUTY_MAX, DUTY_RST defaults, FSM state enum (2-bit), repeat counter width localparam (clog2 of max(REPEAT_DELAY,REPEAT_RATE)+1).
- Sub-module btn_debounce (synchroniser + debounce counter, parameter DEB_CYCLES, ports clk, reset, raw, level), instantiated twice.

Test Plan:
- Reset: assert reset 2 cycles -> duty=5, all pulses 0, at_limit=0.
- Single press: btn_incrPWM high 20 cycles -> duty 5->6 exactly DEB_CYCLES+3=11 edges after rise, inled one pulse, no repeat.
- Bounce: 3-cycle high glitches on btn_decrPWM every 5 cycles -> duty stays 5, no deled.
- Auto-repeat: hold btn_incrPWM 800 cycles -> steps at t0, t0+500, t0+600, t0+700 -> duty 9, four inled pulses.
- Saturation: from duty=9 hold incr 1200 cycles -> duty 10, at_limit=1, exactly one inled; decrement from 0 likewise produces no deled.
- Simultaneous/mid-op reset: press both together -> no change, BOTH until released; reset during HOLD_DEC auto-repeat -> duty=5 next cycle, one further step after DEB_CYCLES+3 while held.
